// File: rtl/button_pkg.sv
// Shared types and helpers for the button event path: press-state encoding,
// the event record and the button-index width rule.
package button_pkg;

  localparam int NBTN_DEFAULT = 4;

  // Widest button index the event record can carry.
  localparam int EVT_IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } press_state_e;

  typedef struct packed {
    logic [EVT_IDX_W-1:0] btn;
    logic                 long_press;
  } btn_event_t;

  // Button index width, never narrower than one bit.
  function automatic int btn_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_press_fsm.sv
// Single-button press classifier: waits until the button has been seen
// released once after reset, then reports a short press on release or a
// long press once the hold threshold is reached.
module button_press_fsm
  import button_pkg::*;
#(
  parameter int LONG_TICKS = 6000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic held,
  output logic evt_strobe,
  output logic evt_long
);

  localparam int CW = (LONG_TICKS > 2) ? $clog2(LONG_TICKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LONG_TICKS - 1);

  press_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // State, hold counter and arm bit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  // Next state and event strobe; the strobe fires on the transition edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    armed_d    = armed_q | ~btn_in;
    evt_strobe = 1'b0;
    evt_long   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (armed_q && btn_in) begin
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end
      end
      ST_PRESSED: begin
        if (!btn_in) begin
          state_d    = ST_IDLE;
          evt_strobe = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = ST_LONG;
          evt_strobe = 1'b1;
          evt_long   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_LONG: begin
        if (!btn_in) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign held = (state_q == ST_LONG);

endmodule

// File: rtl/button_event_arbiter.sv
// Merges per-button press events into a small FIFO: one pending slot per
// button, a round-robin grant into the FIFO, and a sticky drop flag for
// events that arrive while their button's slot is still occupied.
module button_event_arbiter
  import button_pkg::*;
#(
  parameter int NBTN       = NBTN_DEFAULT,
  parameter int LONG_TICKS = 6000000,
  parameter int FIFO_DEPTH = 4,
  localparam int BW        = btn_width(NBTN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [BW-1:0]   evt_btn,
  output logic            evt_long,
  output logic [NBTN-1:0] held,
  output logic            evt_drop,
  input  logic            clr_drop
);

  localparam int PW   = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNTW = PW + 1;
  localparam int EW   = BW + 1;
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(FIFO_DEPTH);
  localparam logic [BW-1:0]   RR_INIT = BW'(NBTN - 1);

  logic [NBTN-1:0] raise, raise_long;
  logic [NBTN-1:0] pend_valid_q, pend_valid_d, pend_long_q, pend_long_d;
  logic [BW-1:0]   rr_q, rr_d, grant_idx, cand;
  logic            grant_valid, push, pop, fifo_full, drop_set;
  logic            drop_q, drop_d;
  logic [EW-1:0]   fifo_q [FIFO_DEPTH];
  logic [EW-1:0]   fifo_d [FIFO_DEPTH];
  logic [EW-1:0]   head_evt;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, head_sel;
  logic [CNTW-1:0] count_q, count_d;

  for (genvar g = 0; g < NBTN; g++) begin : g_btn
    button_press_fsm #(.LONG_TICKS(LONG_TICKS)) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_in    (btn_in[g]),
      .held      (held[g]),
      .evt_strobe(raise[g]),
      .evt_long  (raise_long[g])
    );
  end

  assign fifo_full = (count_q == DEPTH_C);
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign push      = grant_valid & ~fifo_full;

  // While empty, point at the slot popped last so the outputs keep the old head.
  assign head_sel  = evt_valid ? rd_ptr_q : rd_ptr_q - PW'(1);
  assign head_evt  = fifo_q[head_sel];
  assign evt_btn   = head_evt[EW-1:1];
  assign evt_long  = head_evt[0];
  assign evt_drop  = drop_q;

  // Round-robin search: scan from farthest to nearest so the button right
  // after the pointer is the one left standing.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_q;
    cand        = rr_q;
    for (int off = NBTN; off >= 1; off--) begin
      cand = BW'((int'(rr_q) + off) % NBTN);
      if (pend_valid_q[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    rr_d = push ? grant_idx : rr_q;
  end

  // Pending slots: the grant frees a slot before a same-edge event is stored.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_long_d  = pend_long_q;
    drop_set     = 1'b0;
    for (int i = 0; i < NBTN; i++) begin
      if (push && (grant_idx == BW'(i))) begin
        pend_valid_d[i] = 1'b0;
      end
      if (raise[i]) begin
        if (pend_valid_d[i]) begin
          drop_set = 1'b1;
        end else begin
          pend_valid_d[i] = 1'b1;
          pend_long_d[i]  = raise_long[i];
        end
      end
    end
    drop_d = drop_set | (drop_q & ~clr_drop);
  end

  // FIFO bookkeeping; a full FIFO takes no push even while it pops.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {grant_idx, pend_long_q[grant_idx]};
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    count_d = count_q + CNTW'(push) - CNTW'(pop);
  end

  // All arbiter and FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= '0;
      pend_long_q  <= '0;
      rr_q         <= RR_INIT;
      drop_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) begin
        fifo_q[j] <= '0;
      end
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_long_q  <= pend_long_d;
      rr_q         <= rr_d;
      drop_q       <= drop_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_q       <= fifo_d;
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: directed press scenarios followed by random
// button activity, every cycle compared against a behavioural event model.
module tb_button_event_arbiter;
  import button_pkg::*;

  localparam int NBTN       = 4;
  localparam int LONG_TICKS = 8;
  localparam int FIFO_DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NBTN-1:0] btn_in;
  logic            evt_valid;
  logic            evt_ready;
  logic [1:0]      evt_btn;
  logic            evt_long;
  logic [NBTN-1:0] held;
  logic            evt_drop;
  logic            clr_drop;

  int n_compared   = 0;
  int n_mismatched = 0;
  bit chk_en       = 1'b0;

  button_event_arbiter #(
    .NBTN      (NBTN),
    .LONG_TICKS(LONG_TICKS),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_in   (btn_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_btn  (evt_btn),
    .evt_long (evt_long),
    .held     (held),
    .evt_drop (evt_drop),
    .clr_drop (clr_drop)
  );

  always #5 clk = ~clk;

  // Behavioural model: run[i] counts consecutive high samples of an armed
  // press (0 = not pressing); a press is long once it has been sampled high
  // LONG_TICKS+1 times.
  int         run   [NBTN];
  bit         armed [NBTN];
  bit         pv    [NBTN];
  bit         pl    [NBTN];
  int         rr;
  btn_event_t mq [$];
  btn_event_t last_head;
  bit         mdrop;
  bit         m_pop, m_full, g_ok, m_raise, m_long, m_dropset, b;
  int         g, c;
  btn_event_t ev;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [NBTN-1:0] b_in, input logic rdy,
                               input logic clr, input int cycles);
    btn_in    = b_in;
    evt_ready = rdy;
    clr_drop  = clr;
    repeat (cycles) @(negedge clk);
  endtask

  // Model update at each active edge, reset cleared asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBTN; i++) begin
        run[i] = 0; armed[i] = 0; pv[i] = 0; pl[i] = 0;
      end
      rr = NBTN - 1;
      mq.delete();
      last_head = '0;
      mdrop = 0;
    end else begin
      m_pop  = (mq.size() > 0) && evt_ready;
      m_full = (mq.size() >= FIFO_DEPTH);
      g_ok = 0; g = 0;
      if (!m_full) begin
        for (int k = 1; k <= NBTN; k++) begin
          c = (rr + k) % NBTN;
          if (!g_ok && pv[c]) begin g_ok = 1; g = c; end
        end
      end
      if (m_pop) begin
        last_head = mq[0];
        void'(mq.pop_front());
      end
      if (g_ok) begin
        ev.btn = EVT_IDX_W'(g);
        ev.long_press = pl[g];
        mq.push_back(ev);
        pv[g] = 0;
        rr = g;
      end
      m_dropset = 0;
      for (int i = 0; i < NBTN; i++) begin
        b = btn_in[i];
        m_raise = 0; m_long = 0;
        if (run[i] == 0) begin
          if (armed[i] && b) run[i] = 1;
        end else if (b) begin
          run[i]++;
          if (run[i] == LONG_TICKS + 1) begin m_raise = 1; m_long = 1; end
        end else begin
          if (run[i] <= LONG_TICKS) m_raise = 1;
          run[i] = 0;
        end
        if (!b) armed[i] = 1;
        if (m_raise) begin
          if (pv[i]) m_dropset = 1;
          else begin pv[i] = 1; pl[i] = m_long; end
        end
      end
      mdrop = m_dropset ? 1'b1 : (clr_drop ? 1'b0 : mdrop);
    end
  end

  btn_event_t      exp_ev;
  logic [NBTN-1:0] exp_held;

  // Compare all outputs against the model away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_ev = (mq.size() > 0) ? mq[0] : last_head;
      for (int i = 0; i < NBTN; i++) exp_held[i] = (run[i] > LONG_TICKS);
      checkOutput("evt_valid", 32'(evt_valid), 32'(mq.size() > 0));
      checkOutput("evt_btn",   32'(evt_btn),   32'(exp_ev.btn));
      checkOutput("evt_long",  32'(evt_long),  32'(exp_ev.long_press));
      checkOutput("held",      32'(held),      32'(exp_held));
      checkOutput("evt_drop",  32'(evt_drop),  32'(mdrop));
    end
  end

  initial begin
    btn_in = '0; evt_ready = 1'b0; clr_drop = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_valid", 32'(evt_valid), 32'd0);
    checkOutput("reset_btn",   32'(evt_btn),   32'd0);
    checkOutput("reset_long",  32'(evt_long),  32'd0);
    checkOutput("reset_held",  32'(held),      32'd0);
    checkOutput("reset_drop",  32'(evt_drop),  32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    applyStimulus(4'b0000, 1'b1, 1'b0, 2);
    #2 rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0, 3);

    $display("[TB] short press on button 2");
    applyStimulus(4'b0100, 1'b1, 1'b0, 3);
    applyStimulus(4'b0000, 1'b1, 1'b0, 5);

    $display("[TB] long hold on button 1");
    applyStimulus(4'b0010, 1'b1, 1'b0, 20);
    applyStimulus(4'b0000, 1'b1, 1'b0, 5);

    $display("[TB] simultaneous releases, twice");
    repeat (2) begin
      applyStimulus(4'b1011, 1'b1, 1'b0, 3);
      applyStimulus(4'b0000, 1'b1, 1'b0, 6);
    end

    $display("[TB] six presses with the consumer stalled");
    for (int k = 0; k < 6; k++) begin
      applyStimulus(4'(1 << (k % NBTN)), 1'b0, 1'b0, 2);
      applyStimulus(4'b0000, 1'b0, 1'b0, 2);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 10);

    $display("[TB] drop on blocked pending");
    applyStimulus(4'b1111, 1'b0, 1'b0, 2);
    applyStimulus(4'b0000, 1'b0, 1'b0, 6);
    repeat (2) begin
      applyStimulus(4'b0001, 1'b0, 1'b0, 2);
      applyStimulus(4'b0000, 1'b0, 1'b0, 2);
    end
    applyStimulus(4'b0001, 1'b0, 1'b0, 2);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 2);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1);
    applyStimulus(4'b0000, 1'b1, 1'b0, 10);

    $display("[TB] button 3 held through reset release");
    #2 rst_n = 1'b0;
    applyStimulus(4'b1000, 1'b1, 1'b0, 3);
    #2 rst_n = 1'b1;
    applyStimulus(4'b1000, 1'b1, 1'b0, 12);
    applyStimulus(4'b0000, 1'b1, 1'b0, 3);
    applyStimulus(4'b1000, 1'b1, 1'b0, 2);
    applyStimulus(4'b0000, 1'b1, 1'b0, 5);

    $display("[TB] asynchronous reset mid-press");
    applyStimulus(4'b0010, 1'b0, 1'b0, 12);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(evt_valid), 32'd0);
    checkOutput("async_btn",   32'(evt_btn),   32'd0);
    checkOutput("async_long",  32'(evt_long),  32'd0);
    checkOutput("async_held",  32'(held),      32'd0);
    checkOutput("async_drop",  32'(evt_drop),  32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b0, 2);
    #2 rst_n = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0, 2);

    $display("[TB] random activity");
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [NBTN-1:0] nb;
      nb = btn_in;
      for (int i = 0; i < NBTN; i++) begin
        if ($urandom_range(0, 5) == 0) nb[i] = ~nb[i];
      end
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        applyStimulus(nb, 1'b1, 1'b0, 1);
        #2 rst_n = 1'b1;
      end
      applyStimulus(nb, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1);
    end
    applyStimulus(4'b0000, 1'b1, 1'b0, 20);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
